// File: rtl/mprj_io_buffer_pipe.sv
// mprj_io_buffer_pipe: registered management GPIO buffer between housekeeping and the mprj_io pad ring
//  clk               clock, single domain
//  resetn            asynchronous active-low reset
//  VDD, VSS          power pins, only when USE_POWER_PINS is defined
//  freeze            1 = tristate pads (oeb all 1s) and hold output data
//  filt_len          glitch-filter stable-cycle threshold
//  mgmt_gpio_in      raw pad inputs, asynchronous to clk
//  mgmt_gpio_in_buf  synchronised (and optionally filtered) inputs
//  in_event          one-cycle pulse after any bit of mgmt_gpio_in_buf changes
//  mgmt_gpio_oeb     active-low output enables from housekeeping
//  mgmt_gpio_oeb_buf retimed output enables to pads
//  mgmt_gpio_out     output data from housekeeping
//  mgmt_gpio_out_buf retimed output data to pads
// Define MPRJ_IO_BUF_FILTER_EN to add the per-bit glitch filter after the synchroniser.
module mprj_io_buffer_pipe #(
  parameter int N_IN        = 18,
  parameter int N_OEB       = 3,
  parameter int N_OUT       = 18,
  parameter int SYNC_STAGES = 2,
  parameter int OUT_STAGES  = 1,
  parameter int FILT_CNT_W  = 4
) (
`ifdef USE_POWER_PINS
  inout  wire                   VDD,
  inout  wire                   VSS,
`endif
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  freeze,
  input  logic [FILT_CNT_W-1:0] filt_len,
  input  logic [N_IN-1:0]       mgmt_gpio_in,
  output logic [N_IN-1:0]       mgmt_gpio_in_buf,
  output logic                  in_event,
  input  logic [N_OEB-1:0]      mgmt_gpio_oeb,
  output logic [N_OEB-1:0]      mgmt_gpio_oeb_buf,
  input  logic [N_OUT-1:0]      mgmt_gpio_out,
  output logic [N_OUT-1:0]      mgmt_gpio_out_buf
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("mprj_io_buffer_pipe: SYNC_STAGES must be 2..3");
  end
  if (OUT_STAGES < 0 || OUT_STAGES > 3) begin : g_bad_out
    $error("mprj_io_buffer_pipe: OUT_STAGES must be 0..3");
  end
`ifdef USE_POWER_PINS
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;
`endif
  logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q;
  logic [N_IN-1:0] sync_w, in_buf_w, in_prev_q;
  logic in_event_q;
  assign sync_w = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], mgmt_gpio_in};
`ifdef MPRJ_IO_BUF_FILTER_EN
  logic [N_IN-1:0] in_buf_q, in_buf_d;
  logic [N_IN-1:0][FILT_CNT_W-1:0] cnt_q, cnt_d;
  // A bit is released once it has disagreed for more than filt_len cycles; the >= compare
  // makes a lowered threshold take effect on the very next cycle and keeps the counter from wrapping.
  always_comb begin
    in_buf_d = in_buf_q;
    cnt_d = cnt_q;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = (sync_w[i] == in_buf_q[i] || cnt_q[i] >= filt_len) ? '0 : cnt_q[i] + 1'b1;
      in_buf_d[i] = (cnt_q[i] >= filt_len) ? sync_w[i] : in_buf_q[i];
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      in_buf_q <= '0;
      cnt_q <= '0;
    end else begin
      in_buf_q <= in_buf_d;
      cnt_q <= cnt_d;
    end
  assign in_buf_w = in_buf_q;
`else
  logic unused_filt;
  assign unused_filt = ^filt_len;
  assign in_buf_w = sync_w;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      in_prev_q <= '0;
      in_event_q <= 1'b0;
    end else begin
      in_prev_q <= in_buf_w;
      in_event_q <= in_buf_w != in_prev_q;
    end
  assign mgmt_gpio_in_buf = in_buf_w;
  assign in_event = in_event_q;
  if (OUT_STAGES == 0) begin : g_comb
    assign mgmt_gpio_out_buf = mgmt_gpio_out;
    assign mgmt_gpio_oeb_buf = mgmt_gpio_oeb | {N_OEB{freeze}};
  end else begin : g_pipe
    localparam int OUT_W = OUT_STAGES * N_OUT;
    localparam int OEB_W = OUT_STAGES * N_OEB;
    logic [OUT_STAGES-1:0][N_OUT-1:0] out_q, out_d, out_sh;
    logic [OUT_STAGES-1:0][N_OEB-1:0] oeb_q, oeb_d, oeb_sh;
    // Every stage loads its predecessor; only the final stage honours freeze, so values
    // shifted in while frozen are overwritten rather than replayed.
    assign out_sh = OUT_W'({out_q, mgmt_gpio_out});
    assign oeb_sh = OEB_W'({oeb_q, mgmt_gpio_oeb});
    always_comb begin
      out_d = out_sh;
      oeb_d = oeb_sh;
      out_d[OUT_STAGES-1] = freeze ? out_q[OUT_STAGES-1] : out_sh[OUT_STAGES-1];
      oeb_d[OUT_STAGES-1] = freeze ? {N_OEB{1'b1}} : oeb_sh[OUT_STAGES-1];
    end
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        out_q <= '0;
        oeb_q <= '1;
      end else begin
        out_q <= out_d;
        oeb_q <= oeb_d;
      end
    assign mgmt_gpio_out_buf = out_q[OUT_STAGES-1];
    assign mgmt_gpio_oeb_buf = oeb_q[OUT_STAGES-1];
  end
endmodule
